// File: rtl/scrisc_pkg.sv
// Shared SCRISC-16 definitions used by the fetch unit and the datapath.
package scrisc_pkg;

    localparam int unsigned XLEN     = 16;
    localparam int unsigned PC_INCR  = 2;
    localparam logic [XLEN-1:0] RESET_PC = 16'h0000;

    typedef logic [XLEN-1:0] instr_t;
    typedef logic [XLEN-1:0] addr_t;

    // Fetched word paired with its address, as buffered ahead of the datapath.
    typedef struct packed {
        addr_t  pc;
        instr_t instr;
    } fetch_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// Synchronous prefetch FIFO holding {pc, instr} pairs; flush empties it in one cycle.
module ifu_fifo #(
    parameter  int unsigned DEPTH = 4,
    parameter  int unsigned DW    = 32,
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic [DW-1:0] data_i,
    input  logic          pop_i,
    output logic [DW-1:0] data_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    // Pointer and occupancy update; flush wins over push and pop.
    always_comb begin
        do_push  = push_i && !flush_i && (!full_o || pop_i);
        do_pop   = pop_i && !flush_i && !empty_o;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is cleared on reset so the head reads zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// SCRISC-16 instruction fetch: owns the fetch PC, one-deep imem req/ack, prefetch queue, redirect flush.
// Define IFU_BYPASS_EN to forward an ack straight to the datapath when the queue is empty.
module instr_fetch_unit #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = scrisc_pkg::XLEN
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            instr_ready,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc
);

    import scrisc_pkg::*;

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned DW = 2 * XLEN;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic            outstanding_q, outstanding_d;
    logic            discard_q, discard_d;

    logic            ack_hit;
    logic            ack_keep;
    logic            take_c;
    logic            fifo_push;
    logic            fifo_pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count;
    logic [CW-1:0]   count_nxt;
    logic [DW-1:0]   fifo_head;

    assign ack_hit  = outstanding_q && imem_ack;
    assign ack_keep = ack_hit && !discard_q && !redirect;

    assign imem_req  = outstanding_q;
    assign imem_addr = addr_q;

`ifdef IFU_BYPASS_EN
    logic bypass_c;

    assign bypass_c    = ack_keep && fifo_empty;
    assign take_c      = bypass_c && instr_ready;
    assign instr_valid = !fifo_empty || bypass_c;
    assign instr       = bypass_c ? imem_rdata : fifo_head[XLEN-1:0];
    assign instr_pc    = bypass_c ? addr_q     : fifo_head[DW-1:XLEN];
`else
    assign take_c      = 1'b0;
    assign instr_valid = !fifo_empty;
    assign instr       = fifo_head[XLEN-1:0];
    assign instr_pc    = fifo_head[DW-1:XLEN];
`endif

    // Queue traffic, next fetch PC and the single-outstanding request tracker.
    always_comb begin
        fifo_pop      = !fifo_empty && instr_ready && !redirect;
        fifo_push     = ack_keep && !take_c && (!fifo_full || fifo_pop);
        count_nxt     = redirect ? '0 : fifo_count + CW'(fifo_push) - CW'(fifo_pop);
        fetch_pc_d    = fetch_pc_q;
        addr_d        = addr_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;

        if (redirect) begin
            fetch_pc_d = redirect_pc & ~XLEN'(1);
        end else if (ack_hit && !discard_q) begin
            fetch_pc_d = fetch_pc_q + XLEN'(PC_INCR);
        end

        // An unacked request keeps its address; a redirect only marks it for dropping.
        if (outstanding_q && !imem_ack) begin
            if (redirect) begin
                discard_d = 1'b1;
            end
        end else begin
            discard_d     = 1'b0;
            outstanding_d = (count_nxt < CW'(DEPTH));
            if (outstanding_d) begin
                addr_d = fetch_pc_d;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q    <= XLEN'(RESET_PC);
            addr_q        <= '0;
            outstanding_q <= 1'b0;
            discard_q     <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            addr_q        <= addr_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    ifu_fifo #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .flush_i (redirect),
        .push_i  (fifo_push),
        .data_i  ({addr_q, imem_rdata}),
        .pop_i   (fifo_pop),
        .data_o  (fifo_head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: memory responder + random datapath, scoreboard of expected {pc, instr}.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        instr_valid;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        instr_ready;
    logic        redirect;
    logic [15:0] redirect_pc;

    int n_tests = 0;
    int n_fail  = 0;
    int n_acks  = 0;
    int mem_mode = 0;   // 0: never ack, 1: zero-wait ack, 2: random ack

`ifdef IFU_BYPASS_EN
    localparam logic BYPASS = 1'b1;
`else
    localparam logic BYPASS = 1'b0;
`endif

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .DEPTH (4),
        .XLEN  (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    // Instruction memory contents as a fixed function of the address.
    function automatic logic [15:0] mem_fn(input logic [15:0] a);
        logic [15:0] sw;
        sw = {a[7:0], a[15:8]};
        return (a * 16'd37) ^ 16'h5A3C ^ sw;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus driven at the falling edge; returns 2ns later.
    task automatic step(input logic rdy, input logic rdr, input logic [15:0] tgt);
        @(negedge clk);
        instr_ready = rdy;
        redirect    = rdr;
        redirect_pc = tgt;
        case (mem_mode)
            0:       imem_ack = 1'b0;
            1:       imem_ack = imem_req;
            default: imem_ack = imem_req && ($urandom_range(0, 9) < 6);
        endcase
        imem_rdata = imem_req ? mem_fn(imem_addr) : 16'($urandom);
        if (imem_ack) n_acks++;
        #2;
    endtask

    // Reference model: after reset or a redirect the datapath sees target, target+2, ... in order.
    logic [15:0] model_pc = 16'h0000;
    logic [31:0] exp_q[$];
    logic        prev_req = 1'b0;
    logic        prev_ack = 1'b0;
    logic [15:0] prev_addr = 16'h0000;
    int          stall = 0;

    always @(negedge clk) begin
        logic [31:0] e;
        #1;
        if (!reset) begin
            exp_q.delete();
            model_pc = 16'h0000;
            prev_req = 1'b0;
            stall    = 0;
        end else begin
            if (prev_req && !prev_ack) begin
                check("req_hold", 32'(imem_req), 32'd1);
                check("addr_hold", 32'(imem_addr), 32'(prev_addr));
            end
            if (imem_req) check("addr_even", 32'(imem_addr[0]), 32'd0);
            if (redirect) begin
                exp_q.delete();
                model_pc = {redirect_pc[15:1], 1'b0};
                stall    = 0;
            end else if (instr_valid && instr_ready) begin
                e = exp_q.pop_front();
                check("pop_pc", 32'(instr_pc), 32'(e[31:16]));
                check("pop_instr", 32'(instr), 32'(e[15:0]));
                stall = 0;
            end else if (instr_ready && mem_mode != 0) begin
                stall++;
                if (stall > 60) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL progress: no instruction delivered for %0d cycles, expected one", stall);
                    stall = 0;
                end
            end
            while (exp_q.size() < 4) begin
                exp_q.push_back({model_pc, mem_fn(model_pc)});
                model_pc = model_pc + 16'd2;
            end
            prev_req  = imem_req;
            prev_ack  = imem_ack;
            prev_addr = imem_addr;
        end
    end

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int          cnt;
        logic [15:0] hold_addr;

        reset = 1'b0; instr_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
        imem_ack = 1'b0; imem_rdata = '0;
        repeat (2) step(1'b0, 1'b0, 16'h0);
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_addr", 32'(imem_addr), 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", 32'(instr), 32'd0);
        check("rst_pc", 32'(instr_pc), 32'd0);

        // Release: first request at 0, then the ack-to-valid latency.
        @(negedge clk);
        reset = 1'b1;
        mem_mode = 1;
        step(1'b0, 1'b0, 16'h0);
        check("first_req", 32'(imem_req), 32'd1);
        check("first_addr", 32'(imem_addr), 32'h0000);
        check("ack_same_cycle_valid", 32'(instr_valid), 32'(BYPASS));
        step(1'b0, 1'b0, 16'h0);
        check("latency_valid", 32'(instr_valid), 32'd1);
        check("latency_pc", 32'(instr_pc), 32'h0000);
        check("latency_instr", 32'(instr), 32'(mem_fn(16'h0000)));

        // Steady streaming: a request every cycle with a zero-wait memory.
        repeat (10) step(1'b1, 1'b0, 16'h0);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0, 16'h0);
            if (imem_req) cnt++;
        end
        check("stream_req_cycles", 32'(cnt), 32'd20);

        // Full queue: exactly DEPTH requests, then one pop re-opens fetch.
        step(1'b0, 1'b1, 16'h0100);
        n_acks = 0;
        repeat (12) step(1'b0, 1'b0, 16'h0);
        check("full_acks", 32'(n_acks), 32'd4);
        check("full_req_low", 32'(imem_req), 32'd0);
        step(1'b1, 1'b0, 16'h0);
        step(1'b0, 1'b0, 16'h0);
        check("refill_req", 32'(imem_req), 32'd1);
        check("refill_addr", 32'(imem_addr), 32'h0108);
        repeat (10) step(1'b1, 1'b0, 16'h0);

        // Redirect while a request is stalled: old address held, its data dropped.
        repeat (5) step(1'b1, 1'b0, 16'h0);
        mem_mode = 0;
        step(1'b1, 1'b0, 16'h0);
        check("stall_setup_req", 32'(imem_req), 32'd1);
        hold_addr = imem_addr;
        step(1'b1, 1'b1, 16'h0041);
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b0, 16'h0);
            check("discard_req_hold", 32'(imem_req), 32'd1);
            check("discard_addr_hold", 32'(imem_addr), 32'(hold_addr));
        end
        mem_mode = 1;
        step(1'b1, 1'b0, 16'h0);
        step(1'b1, 1'b0, 16'h0);
        check("target_req", 32'(imem_req), 32'd1);
        check("target_addr", 32'(imem_addr), 32'h0040);
        repeat (8) step(1'b1, 1'b0, 16'h0);

        // Redirect coinciding with an ack and a pop.
        repeat (2) step(1'b0, 1'b0, 16'h0);
        step(1'b1, 1'b0, 16'h0);
        step(1'b1, 1'b1, 16'h0200);
        check("coinc_setup_ack", 32'(imem_ack), 32'd1);
        check("coinc_setup_valid", 32'(instr_valid), 32'd1);
        mem_mode = 0;
        step(1'b1, 1'b0, 16'h0);
        check("coinc_empty", 32'(instr_valid), 32'd0);
        check("coinc_req", 32'(imem_req), 32'd1);
        check("coinc_addr", 32'(imem_addr), 32'h0200);
        mem_mode = 1;
        repeat (8) step(1'b1, 1'b0, 16'h0);

        // Address wrap at the top of memory.
        step(1'b1, 1'b1, 16'hFFFE);
        step(1'b1, 1'b0, 16'h0);
        check("wrap_addr0", 32'(imem_addr), 32'hFFFE);
        step(1'b1, 1'b0, 16'h0);
        check("wrap_addr1", 32'(imem_addr), 32'h0000);
        repeat (8) step(1'b1, 1'b0, 16'h0);

        // Random traffic: memory wait states, datapath back-pressure, redirects.
        mem_mode = 2;
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 31) == 0), 16'($urandom));
        end

        // Asynchronous reset with three entries queued and a request in flight.
        mem_mode = 1;
        step(1'b0, 1'b1, 16'h0300);
        repeat (3) step(1'b0, 1'b0, 16'h0);
        mem_mode = 0;
        step(1'b0, 1'b0, 16'h0);
        check("midrst_setup_valid", 32'(instr_valid), 32'd1);
        check("midrst_setup_addr", 32'(imem_addr), 32'h0306);
        #1;
        reset = 1'b0;
        #1;
        check("midrst_req", 32'(imem_req), 32'd0);
        check("midrst_addr", 32'(imem_addr), 32'd0);
        check("midrst_valid", 32'(instr_valid), 32'd0);
        check("midrst_instr", 32'(instr), 32'd0);
        check("midrst_pc", 32'(instr_pc), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        mem_mode = 1;
        step(1'b1, 1'b0, 16'h0);
        check("post_rst_req", 32'(imem_req), 32'd1);
        check("post_rst_addr", 32'(imem_addr), 32'h0000);
        repeat (20) step(1'b1, 1'b0, 16'h0);

        repeat (3) step(1'b0, 1'b0, 16'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch unit for the SCRISC-16 core, sitting directly upstream of the datapath. It owns the fetch PC and issues word requests to instruction memory over a req/ack handshake. Returned instructions are buffered, with their PCs, in a small prefetch queue, and the datapath pops them through a valid/ready interface. Branch and jump redirects from the datapath flush the queue and restart fetch at the target.

## Interface
Parameters:
- `DEPTH`, 4: prefetch queue entries; power of two, at least 2.
- `XLEN`, 16: instruction and address width.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `imem_req`, out, 1: fetch request to instruction memory.
- `imem_addr`, out, XLEN: fetch address; always even.
- `imem_ack`, in, 1: memory has accepted the request; `imem_rdata` is valid this cycle.
- `imem_rdata`, in, XLEN: fetched instruction word.
- `instr_valid`, out, 1: the head of the queue holds an instruction.
- `instr`, out, XLEN: head instruction.
- `instr_pc`, out, XLEN: PC of the head instruction.
- `instr_ready`, in, 1: datapath consumes the head this cycle.
- `redirect`, in, 1: branch or jump taken; flush the queue and refetch.
- `redirect_pc`, in, XLEN: redirect target; bit 0 is forced to 0.

## Operation
- State:
  - `fetch_pc`: next address to request.
  - Queue: `count` plus read and write pointers.
  - `outstanding`: one request in flight.
  - `discard`: drop the next ack.
- Issue condition: a request is issued when `count + outstanding < DEPTH` and no request is already in flight. At most one request is in flight at a time.
- Handshake:
  - `imem_req` and `imem_addr` stay asserted and stable from issue until the cycle of `imem_ack`.
  - On ack, `fetch_pc <= fetch_pc + 2`, wrapping modulo 2^XLEN (0xFFFE -> 0x0000).
  - A new request may be issued in the cycle after the ack.
- On ack with `discard` clear: `{imem_rdata, imem_addr}` is pushed into the queue.
- Pop: a pop happens when `instr_valid && instr_ready`. Pop and push in the same cycle leave `count` unchanged.
- Redirect, with priority over pop and push in that cycle:
  - The queue empties (`count <= 0`) and the pop is ignored.
  - `fetch_pc <= {redirect_pc[XLEN-1:1], 1'b0}`.
  - If a request is in flight and is not acked this cycle, `discard <= 1`. The in-flight request stays asserted at its old address until its ack, and that ack's data is dropped. The target is requested in the cycle after that ack.
  - If the ack coincides with the redirect, the ack data is dropped and `discard` stays 0.
- `instr_valid` never asserts for discarded data. `instr` and `instr_pc` are don't-care while `instr_valid` is 0.

## Timing
- Reset values (asynchronous, while `reset` is low): `fetch_pc=0`, `count=0`, `outstanding=0`, `discard=0`, `imem_req=0`, `imem_addr=0`, `instr_valid=0`, `instr=0`, `instr_pc=0`.
- First request: `imem_req` rises in the first cycle after `reset` deasserts, with `imem_addr=0x0000`.
- Reset asserted mid-transaction: all state is cleared immediately and the in-flight request is abandoned. Memory must tolerate the dropped request.
- Latency (default build): `imem_ack` in cycle N gives `instr_valid` in cycle N+1.
- Full queue: `imem_req` stays low until a pop frees a slot; the request then issues in the cycle after that pop.
- Empty queue: `instr_valid=0`, and `instr_ready` is ignored.
- Redirect to first valid target instruction: at least 2 cycles with a zero-wait memory.

## Configuration
- `IFU_BYPASS_EN`:
  - Defined: when the queue is empty and a non-discarded ack arrives, `instr`, `instr_pc` and `instr_valid` are driven combinationally from `imem_rdata` and `imem_addr` in the same cycle. If `instr_ready` is also high, the word is consumed without being pushed; otherwise it is pushed. Zero-cycle fetch latency.
  - Undefined: every word passes through the queue, giving 1-cycle latency and registered outputs only.

## Structure
- Shared package `scrisc_pkg`: `XLEN`, `PC_INCR` (= 2), `RESET_PC` (= 16'h0000), and the `instr_t` / `addr_t` typedefs, shared with the datapath.
- One sub-module, `ifu_fifo`: a synchronous FIFO of `{pc, instr}` with push, pop, flush, count, full and empty. The fetch control logic and the handshake live in `instr_fetch_unit`.

## Test plan
- Reset release with memory acking 1 cycle after each req and `instr_ready=1`: `imem_addr` runs 0x0000, 0x0002, 0x0004…; `instr_pc` matches in order; no gaps in steady state beyond the 1-request limit.
- `instr_ready=0` held: exactly DEPTH=4 requests issue, then `imem_req` stays low. A single pop causes one new req in the next cycle.
- Request 0x0006 outstanding, `redirect=1` with `redirect_pc=0x0041`: `imem_addr` holds 0x0006 until ack, and that data never appears. The next req is 0x0040, and the first `instr_pc` is 0x0040.
- Redirect in the same cycle as an ack and a pop: the queue is empty next cycle, the acked word is dropped, and fetch resumes at the target.
- `redirect_pc=0xFFFE`, zero-wait memory: PCs 0xFFFE then 0x0000.
- Assert `reset` low mid-request with 3 entries queued: outputs go to their reset values immediately, and the first req after release is at 0x0000. With `IFU_BYPASS_EN` defined, an empty queue plus an ack gives `instr_valid` in the same cycle.
